// File: rtl/alu_muldiv_if.sv
// Execute-stage ALU bus: operands, op select, result flags and the multiply/divide
// command handshake, bundled so the pipeline and the bench see one port.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUctr;
  logic             start;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  // Handshake: start is a one-cycle request that is honoured only while busy=0;
  // while busy=1 every start is dropped. done pulses for one cycle when HI/LO
  // have just taken the new result, and busy falls on the following edge.
  modport master (
    output A, B, ALUctr, start,
    input  out, zero, busy, done, state_dbg
  );

  modport slave (
    input  A, B, ALUctr, start,
    output out, zero, busy, done, state_dbg
  );
endinterface

// File: rtl/alu_muldiv.sv
// MIPS execute-stage ALU: combinational integer ops plus an iterative unsigned
// multiply/divide unit that owns the architectural HI/LO registers.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADDU  = 4'd0;
  localparam logic [3:0] OP_SUBU  = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_LUI   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_MULTU = 4'd8;
  localparam logic [3:0] OP_DIVU  = 4'd9;
  localparam logic [3:0] OP_MFHI  = 4'd10;
  localparam logic [3:0] OP_MFLO  = 4'd11;
  localparam logic [3:0] OP_MTHI  = 4'd12;
  localparam logic [3:0] OP_MTLO  = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [2*WIDTH-1:0] acc;
  logic               is_div;
  logic               load_pend;

  logic               md_req;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, step;

  assign md_req    = bus.start && (bus.ALUctr == OP_MULTU || bus.ALUctr == OP_DIVU);
  assign last_iter = !load_pend && (cnt == CW'(WIDTH - 1));

  // One iteration of either algorithm. Divide keeps {remainder, quotient} in acc so
  // the final value lands directly as {HI, LO}, exactly like the product does.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_a} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_trial = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, op_b};
    if (!div_trial[WIDTH+1])
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_next = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
    step = is_div ? div_next : mul_next;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (md_req) state_n = S_RUN;
      S_RUN:   if (last_iter) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      is_div    <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (md_req) begin
            op_a      <= bus.A;
            op_b      <= bus.B;
            is_div    <= (bus.ALUctr == OP_DIVU);
            cnt       <= '0;
            load_pend <= 1'b1;
          end else if (bus.start && bus.ALUctr == OP_MTHI) begin
            hi <= bus.A;
          end else if (bus.start && bus.ALUctr == OP_MTLO) begin
            lo <= bus.A;
          end
        end
        S_RUN: begin
          // First RUN cycle seeds the accumulator from the latched operands.
          if (load_pend) begin
            acc       <= is_div ? {{WIDTH{1'b0}}, op_a} : {{WIDTH{1'b0}}, op_b};
            load_pend <= 1'b0;
          end else begin
            acc <= step;
            cnt <= cnt + CW'(1);
            if (last_iter) begin
              hi <= step[2*WIDTH-1:WIDTH];
              lo <= step[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.out = '0;
    case (bus.ALUctr)
      OP_ADDU: bus.out = bus.A + bus.B;
      OP_SUBU: bus.out = bus.A - bus.B;
      OP_OR:   bus.out = bus.A | bus.B;
      OP_AND:  bus.out = bus.A & bus.B;
      OP_XOR:  bus.out = bus.A ^ bus.B;
      OP_LUI:  bus.out = bus.B;
      OP_SLT:  bus.out = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU: bus.out = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_MFHI: bus.out = hi;
      OP_MFLO: bus.out = lo;
      default: bus.out = '0;
    endcase
  end

  assign bus.zero      = (bus.A == bus.B);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.state_dbg = state;

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised execute-stage ALU for the MIPS pipeline. It extends the single-cycle operation set with signed and unsigned compares and AND/XOR. It adds an iterative unsigned multiply/divide unit with architectural HI/LO registers and a start/busy/done handshake. Single-cycle results are combinational; multiply and divide run for WIDTH cycles, and hazard control stalls on `busy`.

## Interface
- `WIDTH`, 32, datapath width. Must be even and ≥4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous reset, active-low. Sampled on the `clk` rising edge.
- `A`  in  WIDTH  operand A (rs).
- `B`  in  WIDTH  operand B (rt or extended immediate).
- `ALUctr`  in  4  operation select.
- `start`  in  1  qualifies MULTU/DIVU/MTHI/MTLO for one cycle.
- `out`  out  WIDTH  combinational result.
- `zero`  out  1  combinational, 1 when A==B.
- `busy`  out  1  multiply/divide unit not idle.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.

## Operation
- ALUctr encodings:
  - 0 ADDU: A+B, wraps mod 2^WIDTH.
  - 1 SUBU: A−B, wraps.
  - 2 OR.
  - 3 AND.
  - 4 XOR.
  - 5 LUI: out=B.
  - 6 SLT: signed A<B gives 1, else 0, zero-extended.
  - 7 SLTU: unsigned compare, same format as SLT.
  - 8 MULTU.
  - 9 DIVU.
  - 10 MFHI: out=HI.
  - 11 MFLO: out=LO.
  - 12 MTHI.
  - 13 MTLO.
  - 14–15: out=0.
- For ops 8, 9, 12 and 13, out=0.
- `zero` does not depend on ALUctr.
- MFHI/MFLO return the current register contents. While the unit is busy these are stale values; `busy` is the stall indication.
- FSM states:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, an iteration counter counts 0..WIDTH−1.
  - DONE: busy=1, done=1.
- In IDLE with start=1:
  - ALUctr=MULTU or DIVU: latch A and B, clear the counter, go to RUN.
  - ALUctr=MTHI: HI←A at the edge, stay in IDLE.
  - ALUctr=MTLO: LO←A at the edge, stay in IDLE.
  - Any other ALUctr: start is ignored.
- In RUN or DONE, `start` is ignored for all ops, including MTHI/MTLO.
- RUN performs one iteration per cycle:
  - MULTU: shift-add over a 2·WIDTH product.
  - DIVU: restoring division, one quotient bit per cycle.
- RUN exit: on the edge where counter==WIDTH−1, write HI/LO and go to DONE.
- DONE always returns to IDLE on the next edge.
- MULTU result: {HI,LO} = A×B, full 2·WIDTH-bit unsigned product.
- DIVU result: LO = quotient, HI = remainder.
- DIVU by zero: LO = all ones, HI = dividend. No exception.
- HI/LO are not modified during RUN; the write is atomic at the RUN→DONE edge.
- Reset (rst_n=0 at an edge):
  - State←IDLE, counter←0, HI←0, LO←0, internal operand/partial registers←0.
  - An in-flight operation is aborted and produces no `done`.

## Timing
- With `start` accepted at edge t:
  - busy=1 from t+1 through t+WIDTH+1.
  - done=1 for exactly the cycle between edges t+WIDTH+1 and t+WIDTH+2.
  - New HI/LO are visible from edge t+WIDTH+1.
  - busy=0 after edge t+WIDTH+2.
- Back-to-back: a new start is accepted at edge t+WIDTH+2 at the earliest, i.e. the first IDLE cycle. A start during the DONE cycle is ignored.
- MTHI/MTLO latency: one edge, with no busy or done.
- Combinational outputs (`out`, `zero`) have zero cycles of latency and no reset value.
- Registered outputs after reset: busy=0, done=0.

## Test plan
- **Combinational ops**, WIDTH=32:
  - SLT A=0xFFFFFFFF, B=1 → out=1.
  - SLTU with the same operands → out=0.
  - SUBU 5−5 → out=0, zero=1.
  - ADDU 0xFFFFFFFF+1 → out=0.
  - LUI B=0x12340000 → out=0x12340000.
  - ALUctr=15 → out=0.
- **MULTU**: 0xFFFFFFFF×0xFFFFFFFF, start at edge t.
  - busy rises at t+1; done pulses exactly once at t+33.
  - HI=0xFFFFFFFE, LO=0x00000001.
  - MFHI/MFLO return the old values until t+33.
- **DIVU**:
  - 100/7 → LO=14, HI=2.
  - 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234.
  - Each takes the same 34-cycle busy window as MULTU.
- **Ignored commands**:
  - MTHI A=0xAAAA5555 issued while busy → HI unchanged.
  - Second MULTU start while busy → no restart, a single done.
  - MTLO A=7 when idle → LO=7 after one edge, busy stays 0.
- **Reset mid-operation**: rst_n=0 for one edge at cycle 10 of a DIVU.
  - Next cycle: busy=0, HI=LO=0.
  - No done pulse follows.
  - A fresh MULTU 3×4 afterwards gives LO=12, HI=0.
- **Parametrisation**: WIDTH=8, MULTU 0xFF×0xFF.
  - {HI,LO} = 0xFE01.
  - done at t+9.
